// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// A grant is held for a whole burst. The burst ends on ReqLast or after MAX_BURST words.
// Each release costs one IDLE cycle before the next arbitration.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                            Clk,
   input  logic                            Rst,
   input  logic [NUM_REQ-1:0]              ReqEn,
   input  logic [NUM_REQ-1:0]              ReqValid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   ReqData,
   input  logic [NUM_REQ-1:0]              ReqLast,
   output logic [NUM_REQ-1:0]              ReqReady,
   input  logic                            Full,
   output logic                            Wen,
   output logic [DATA_WIDTH-1:0]           WrData,
   output logic [$clog2(NUM_REQ)-1:0]      GrantId,
   output logic                            Busy
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(MAX_BURST) + 1;
   localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

   typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t          state_reg;
   logic [IW-1:0]   grant_id_reg;
   logic [IW-1:0]   last_grant_reg;
   logic [CW-1:0]   burst_cnt_reg;

   logic [NUM_REQ-1:0]    elig;
   logic [IW-1:0]         cand_idx [NUM_REQ];
   logic [DATA_WIDTH-1:0] data_slice [NUM_REQ];
   logic                  winner_found;
   logic [IW-1:0]         winner_idx;
   logic                  granted;
   logic                  xfer;

   assign elig = ReqValid & ReqEn;

   // Candidate k is LastGrant+1+k; the IW-bit adder overflow gives the modulo wrap.
   // Per-requester data slices feed the write data mux.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slices
         assign cand_idx[gi]   = last_grant_reg + IW'(gi + 1);
         assign data_slice[gi] = ReqData[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   // Priority scan over the rotated candidate list; the first eligible one wins.
   always_comb begin
      winner_found = 1'b0;
      winner_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!winner_found && elig[cand_idx[k]]) begin
            winner_found = 1'b1;
            winner_idx   = cand_idx[k];
         end
      end
   end

   // Reset masks all write-side outputs immediately, even while the state register still says GRANT.
   assign granted = (state_reg == GRANT) && !Rst;
   assign xfer    = granted && ReqValid[grant_id_reg] && !Full;

   assign Wen     = xfer;
   assign Busy    = granted;
   assign GrantId = grant_id_reg;
   assign WrData  = data_slice[grant_id_reg];

   // Only the granted requester sees ready, and only while the FIFO has room.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
         assign ReqReady[gi] = granted && !Full && (grant_id_reg == IW'(gi));
      end
   endgenerate

   // Arbitration FSM: IDLE picks a winner; GRANT counts words and releases on last or burst limit.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_reg      <= IDLE;
         grant_id_reg   <= '0;
         burst_cnt_reg  <= '0;
         last_grant_reg <= IW'(NUM_REQ - 1);
      end else begin
         case (state_reg)
            IDLE: begin
               if (winner_found) begin
                  grant_id_reg   <= winner_idx;
                  last_grant_reg <= winner_idx;
                  burst_cnt_reg  <= '0;
                  state_reg      <= GRANT;
               end
            end
            GRANT: begin
               if (xfer) begin
                  burst_cnt_reg <= burst_cnt_reg + 1'b1;
                  if (ReqLast[grant_id_reg] || (burst_cnt_reg == BURST_LAST)) begin
                     state_reg <= IDLE;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
